// File: rtl/rv32_mem_pkg.sv
// -----------------------------------------------------------------------------
// rv32_mem_pkg
// Shared types and constants for the RV32 data-memory load/store unit:
//   - RV32 load/store funct3 encodings (F3_*)
//   - mem_err_e   : response error codes (NONE, ILLEGAL, MISALIGN, RANGE)
//   - lsu_state_e : load/store unit FSM states (IDLE, ACCESS, RESP)
//   - access_size : number of bytes touched by a given funct3
// -----------------------------------------------------------------------------
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        ILLEGAL  = 2'd1,
        MISALIGN = 2'd2,
        RANGE    = 2'd3
    } mem_err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Byte count of an access; only funct3[1:0] carries the size.
    function automatic logic [2:0] access_size(input logic [2:0] func3);
        logic [2:0] size;
        case (func3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering between the 32-bit memory word and the
// right-aligned register data.
//   func3       in   RV32 load/store funct3
//   lane        in   byte address bits [1:0]
//   wdata       in   right-aligned store data
//   be          out  store byte-lane enables (lane 0 = bits 7:0)
//   wdata_lanes out  store data replicated onto every candidate lane
//   rword       in   raw memory word for a load
//   rdata       out  load result, sign- or zero-extended
// Illegal funct3 values produce no enables and zero load data.
// -----------------------------------------------------------------------------
module dmem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    input  logic [31:0] rword,
    output logic [31:0] rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store path: data is replicated so the enables alone pick the lanes.
    always_comb begin
        be          = 4'b0000;
        wdata_lanes = 32'h0000_0000;
        case (func3)
            F3_B: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{wdata[7:0]}};
            end
            F3_H: begin
                be          = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            F3_W: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
            end
            default: begin
                be          = 4'b0000;
                wdata_lanes = 32'h0000_0000;
            end
        endcase
    end

    // Load path: select the addressed byte/halfword, then extend.
    always_comb begin
        byte_s = rword[{lane, 3'b000} +: 8];
        half_s = lane[1] ? rword[31:16] : rword[15:0];
        case (func3)
            F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
            F3_H:    rdata = {{16{half_s[15]}}, half_s};
            F3_W:    rdata = rword;
            F3_BU:   rdata = {24'h00_0000, byte_s};
            F3_HU:   rdata = {16'h0000, half_s};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// RV32 data-memory load/store unit with a valid/ready request channel and a
// valid/ready response channel. Holds the word array, the access error check
// and the IDLE/ACCESS/RESP FSM.
//   clk, rst      clock; asynchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_we        1 = store, 0 = load
//   req_func3     RV32 funct3
//   req_addr      byte address (AW bits)
//   req_wdata     right-aligned store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata     extended load data; 0 for stores and faults
//   rsp_err       access faulted
//   rsp_err_code  0 none, 1 illegal funct3, 2 misaligned, 3 out of range
// -----------------------------------------------------------------------------
module dmem_lsu
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_func3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [1:0]    rsp_err_code
);

    localparam int           NWORDS    = DEPTH_BYTES / 4;
    localparam int           IW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [AW:0]  DEPTH_LIM = (AW+1)'(DEPTH_BYTES);

    lsu_state_e    state_r;
    logic          we_r;
    logic [2:0]    func3_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;

    logic [31:0]   mem_r [NWORDS];

    logic          accept_s;
    logic          legal_s;
    logic          misalign_s;
    logic [2:0]    size_s;
    logic [AW:0]   last_byte_s;
    mem_err_e      err_s;
    logic [IW-1:0] word_idx_s;
    logic [31:0]   rword_s;
    logic [3:0]    be_s;
    logic [31:0]   wlanes_s;
    logic [31:0]   load_s;
    logic          mem_we_s;

    // The response slot can be refilled in the same cycle it is drained.
    assign req_ready = (state_r == IDLE) || ((state_r == RESP) && rsp_ready);
    assign accept_s  = req_valid && req_ready;

    // Error classification of the captured request, highest priority first.
    always_comb begin
        size_s = access_size(func3_r);
        if (we_r) begin
            case (func3_r)
                F3_B, F3_H, F3_W: legal_s = 1'b1;
                default:          legal_s = 1'b0;
            endcase
        end else begin
            case (func3_r)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: legal_s = 1'b1;
                default:                        legal_s = 1'b0;
            endcase
        end
        misalign_s = ((size_s == 3'd2) && addr_r[0]) ||
                     ((size_s == 3'd4) && (addr_r[1:0] != 2'b00));
        // One extra bit so the end address of the access cannot wrap.
        last_byte_s = {1'b0, addr_r} + {{(AW-2){1'b0}}, size_s}
                    - {{AW{1'b0}}, 1'b1};
        if (!legal_s) begin
            err_s = ILLEGAL;
        end else if (misalign_s) begin
            err_s = MISALIGN;
        end else if (last_byte_s >= DEPTH_LIM) begin
            err_s = RANGE;
        end else begin
            err_s = NONE;
        end
    end

    assign word_idx_s = addr_r[IW+1:2];
    assign rword_s    = mem_r[word_idx_s];
    assign mem_we_s   = (state_r == ACCESS) && we_r && (err_s == NONE);

    dmem_lane_align u_align (
        .func3       (func3_r),
        .lane        (addr_r[1:0]),
        .wdata       (wdata_r),
        .be          (be_s),
        .wdata_lanes (wlanes_s),
        .rword       (rword_s),
        .rdata       (load_s)
    );

    // Word array lane writes; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we_s && be_s[i]) begin
                mem_r[word_idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
            end
        end
    end

    // Control FSM, request capture and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            we_r         <= 1'b0;
            func3_r      <= 3'b000;
            addr_r       <= {AW{1'b0}};
            wdata_r      <= 32'h0000_0000;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0000_0000;
            rsp_err      <= 1'b0;
            rsp_err_code <= 2'b00;
        end else begin
            if (accept_s) begin
                we_r    <= req_we;
                func3_r <= req_func3;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    state_r      <= RESP;
                    rsp_valid    <= 1'b1;
                    rsp_err      <= (err_s != NONE);
                    rsp_err_code <= err_s;
                    rsp_rdata    <= (!we_r && (err_s == NONE)) ? load_s : 32'h0000_0000;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= accept_s ? ACCESS : IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Self-checking bench for dmem_lsu: directed vector table, hand-written
// handshake/reset sequences, then randomized accesses against a byte-array
// reference model.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam int DEPTH = 1024;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_func3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [1:0]    rsp_err_code;

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH_BYTES(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_func3    (req_func3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .rsp_err_code (rsp_err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit [7:0] mem_m [DEPTH];

    typedef struct {
        string     name;
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] rd;
        bit        err;
        bit [1:0]  code;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit [7:0] pf(input int a);
        return 8'(a) ^ 8'hA5;
    endfunction

    function automatic bit [31:0] pw(input int a);
        return {pf(a+3), pf(a+2), pf(a+1), pf(a)};
    endfunction

    function automatic bit [31:0] sx8(input bit [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic bit [31:0] sx16(input bit [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    // Reference model: byte-addressed memory with RV32 access rules.
    function automatic void model_access(input bit we, input bit [2:0] f3,
                                         input bit [31:0] addr, input bit [31:0] wd,
                                         output bit [31:0] rd, output bit [1:0] code);
        bit        legal;
        int        size;
        longint    a;
        bit [31:0] v;
        legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a     = longint'(addr);
        rd    = 32'h0;
        code  = 2'd0;
        if (!legal) code = 2'd1;
        else if ((a % size) != 0) code = 2'd2;
        else if (a + size > DEPTH) code = 2'd3;
        else if (we) begin
            for (int i = 0; i < size; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_m[int'(a) + i]) << (8*i));
            if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
        end
    endfunction

    // One complete request/response with rsp_ready held high.
    task automatic xact(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, output logic [31:0] rd, output logic err,
                        output logic [1:0] code, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b1;
        #1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        rd   = rsp_rdata;
        err  = rsp_err;
        code = rsp_err_code;
    endtask

    function automatic void add(input string n, input bit we, input bit [2:0] f3,
                                input bit [31:0] addr, input bit [31:0] wd,
                                input bit [31:0] rd, input bit [1:0] code);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.rd = rd; v.code = code; v.err = (code != 2'd0);
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd0;
        logic        err;
        logic [1:0]  code;
        bit   [31:0] erd, v;
        bit   [1:0]  ecode;
        int          lat;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_code", 32'(rsp_err_code), 32'd0);
        rst = 1'b0;

        // Known memory image so untouched bytes have predictable values.
        for (int w = 0; w < DEPTH/4; w++) begin
            xact(1'b1, 3'b010, 32'(w*4), pw(w*4), rd, err, code, lat);
            model_access(1'b1, 3'b010, 32'(w*4), pw(w*4), erd, ecode);
        end

        add("sw_10",     1, 3'd2, 32'h10, 32'h8000_00FF, 32'h0, 2'd0);
        add("lw_10",     0, 3'd2, 32'h10, 32'h0, 32'h8000_00FF, 2'd0);
        add("lb_10",     0, 3'd0, 32'h10, 32'h0, 32'hFFFF_FFFF, 2'd0);
        add("lbu_13",    0, 3'd4, 32'h13, 32'h0, 32'h0000_0080, 2'd0);
        add("sh_22",     1, 3'd1, 32'h22, 32'h1234_BEEF, 32'h0, 2'd0);
        add("lh_22",     0, 3'd1, 32'h22, 32'h0, 32'hFFFF_BEEF, 2'd0);
        add("lhu_22",    0, 3'd5, 32'h22, 32'h0, 32'h0000_BEEF, 2'd0);
        add("lhu_20",    0, 3'd5, 32'h20, 32'h0, {16'h0, pf(32'h21), pf(32'h20)}, 2'd0);
        add("lw_20",     0, 3'd2, 32'h20, 32'h0, {8'hBE, 8'hEF, pf(32'h21), pf(32'h20)}, 2'd0);
        add("lw_12_mis", 0, 3'd2, 32'h12, 32'h0, 32'h0, 2'd2);
        add("sh_31_mis", 1, 3'd1, 32'h31, 32'h0000_AAAA, 32'h0, 2'd2);
        add("lw_30",     0, 3'd2, 32'h30, 32'h0, pw(32'h30), 2'd0);
        add("lw_end_m2", 0, 3'd2, 32'(DEPTH-2), 32'h0, 32'h0, 2'd2);
        add("lw_end",    0, 3'd2, 32'(DEPTH), 32'h0, 32'h0, 2'd3);
        add("sw_f3_4",   1, 3'd4, 32'h50, 32'hDEAD_BEEF, 32'h0, 2'd1);
        add("lw_50",     0, 3'd2, 32'h50, 32'h0, pw(32'h50), 2'd0);
        add("lb_last",   0, 3'd0, 32'(DEPTH-1), 32'h0, sx8(pf(DEPTH-1)), 2'd0);
        add("lh_last",   0, 3'd1, 32'(DEPTH-2), 32'h0, sx16({pf(DEPTH-1), pf(DEPTH-2)}), 2'd0);
        add("lw_last",   0, 3'd2, 32'(DEPTH-4), 32'h0, pw(DEPTH-4), 2'd0);
        add("lhu_odd",   0, 3'd5, 32'(DEPTH-1), 32'h0, 32'h0, 2'd2);
        add("lbu_end",   0, 3'd4, 32'(DEPTH), 32'h0, 32'h0, 2'd3);
        add("lb_top",    0, 3'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 2'd3);
        add("lw_top",    0, 3'd2, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'd3);
        add("ld_f3_3",   0, 3'd3, 32'h11, 32'h0, 32'h0, 2'd1);
        add("ld_f3_6",   0, 3'd6, 32'h10, 32'h0, 32'h0, 2'd1);
        add("st_f3_7",   1, 3'd7, 32'(DEPTH+1), 32'h0, 32'h0, 2'd1);
        add("sb_61",     1, 3'd0, 32'h61, 32'hCAFE_0077, 32'h0, 2'd0);
        add("lw_60",     0, 3'd2, 32'h60, 32'h0, {pf(32'h63), pf(32'h62), 8'h77, pf(32'h60)}, 2'd0);
        add("sh_66",     1, 3'd1, 32'h66, 32'h0000_8001, 32'h0, 2'd0);
        add("lw_64",     0, 3'd2, 32'h64, 32'h0, {8'h80, 8'h01, pf(32'h65), pf(32'h64)}, 2'd0);
        add("lh_66",     0, 3'd1, 32'h66, 32'h0, 32'hFFFF_8001, 2'd0);

        foreach (tbl[i]) begin
            xact(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, err, code, lat);
            check({tbl[i].name, "_rdata"}, rd, tbl[i].rd);
            check({tbl[i].name, "_err"}, 32'(err), 32'(tbl[i].err));
            check({tbl[i].name, "_code"}, 32'(code), 32'(tbl[i].code));
            check({tbl[i].name, "_lat"}, 32'(lat), 32'd1);
            model_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, erd, ecode);
        end

        // Back-to-back store then load to the same word.
        v = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'd2; req_addr = 32'h70; req_wdata = v;
        rsp_ready = 1'b1;
        #1 check("b2b_ready0", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_ready_acc", 32'(req_ready), 32'd0);
        check("b2b_valid_acc", 32'(rsp_valid), 32'd0);
        req_we = 1'b0; req_addr = 32'h70; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_st_valid", 32'(rsp_valid), 32'd1);
        check("b2b_st_err", 32'(rsp_err), 32'd0);
        check("b2b_ready_resp", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_ld_acc", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_ld_valid", 32'(rsp_valid), 32'd1);
        check("b2b_ld_rdata", rsp_rdata, v);
        model_access(1'b1, 3'd2, 32'h70, v, erd, ecode);

        // Stalled response: outputs hold, no new request is taken.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h70;
        @(posedge clk);
        @(negedge clk);
        req_func3 = 3'd4; req_addr = 32'h13;
        @(posedge clk);
        @(negedge clk);
        check("stall_valid0", 32'(rsp_valid), 32'd1);
        check("stall_rdata0", rsp_rdata, v);
        rd0 = rsp_rdata;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, rd0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1 check("stall_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("stall_next_acc", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        model_access(1'b0, 3'd4, 32'h13, 32'h0, erd, ecode);
        check("stall_next_valid", 32'(rsp_valid), 32'd1);
        check("stall_next_rdata", rsp_rdata, erd);

        // Reset during ACCESS of a store aborts it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'd2; req_addr = 32'h40;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("racc_ready_before", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("racc_valid", 32'(rsp_valid), 32'd0);
        check("racc_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 3'd2, 32'h40, 32'h0, rd, err, code, lat);
        model_access(1'b0, 3'd2, 32'h40, 32'h0, erd, ecode);
        check("racc_lw40", rd, erd);

        // Reset during RESP drops the response.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rresp_valid_before", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rresp_valid", 32'(rsp_valid), 32'd0);
        check("rresp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Randomized accesses against the reference model.
        for (int n = 0; n < 400; n++) begin
            bit        we;
            bit [2:0]  f3;
            bit [31:0] addr;
            bit [31:0] wd;
            int        sel;
            we  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel < 7)      addr = 32'($urandom_range(0, DEPTH-1));
            else if (sel < 9) addr = 32'(DEPTH - 4 + $urandom_range(0, 7));
            else              addr = $urandom;
            wd = $urandom;
            xact(we, f3, addr, wd, rd, err, code, lat);
            model_access(we, f3, addr, wd, erd, ecode);
            check("rand_rdata", rd, erd);
            check("rand_err", 32'(err), 32'(ecode != 2'd0));
            check("rand_code", 32'(code), 32'(ecode));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
